// File: rtl/bbox_sweep_ctrl.sv
// Truth-table sweeper for a 3-input evaluator: drives vectors 0..7, settles, samples x.
// Optional SWEEP_CHECK_EN adds a compare of the final table against an expected value.
module bbox_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       x_in,
`ifdef SWEEP_CHECK_EN
  input  logic [7:0] expected,
  output logic       mismatch,
  output logic [7:0] fail_mask,
`endif
  output logic       drv_e,
  output logic       drv_u,
  output logic       drv_a,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic [2:0] index
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state, state_d;
  logic [3:0] cnt;
  logic [2:0] idx;
  logic [7:0] tbl, tbl_fin;
  logic       sample;

  // tbl_fin folds in the sample taken this edge so the compare sees the whole table
  always_comb begin
    state_d = state;
    sample  = 1'b0;
    tbl_fin = tbl;
    case (state)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (cnt == SETTLE_C) begin
          sample       = 1'b1;
          tbl_fin[idx] = x_in;
          if (idx == 3'd7) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= 3'd0;
      cnt <= 4'd0;
      tbl <= 8'h00;
`ifdef SWEEP_CHECK_EN
      fail_mask <= 8'h00;
      mismatch  <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (start) begin
        idx <= 3'd0;
        cnt <= 4'd0;
        tbl <= 8'h00;
`ifdef SWEEP_CHECK_EN
        fail_mask <= 8'h00;
        mismatch  <= 1'b0;
`endif
      end
    end else if (state == RUN) begin
      if (sample) begin
        tbl <= tbl_fin;
        cnt <= 4'd0;
        // 7 -> 0 coincides with entering DONE, which presents index 0
        idx <= idx + 3'd1;
`ifdef SWEEP_CHECK_EN
        if (idx == 3'd7) begin
          fail_mask <= tbl_fin ^ expected;
          mismatch  <= |(tbl_fin ^ expected);
        end
`endif
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign busy                  = (state == RUN);
  assign done                  = (state == DONE);
  assign {drv_e, drv_u, drv_a} = busy ? idx : 3'd0;
  assign index                 = idx;
  assign truth_table           = tbl;

endmodule
